gpr_move_sequencer: RTL and testbench

Control stage directly upstream of the GPRegister bank. It turns a single-cycle move request into the timed active-low strobes the general-purpose registers consume: per-register notOE and notLoad lines. Two move kinds are supported: register-to-register across the shared 16-bit data bus, and immediate-to-register, where the sequencer drives the bus itself. Bus contention is prevented by construction.

---
 rtl/gpr_move_sequencer.sv | 120 ++++++++++++
 tb/tb_gpr_move_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_move_sequencer.sv
// Sequences reg->reg and imm->reg moves into registered active-low notOE/notLoad strobes; 3-cycle move (2 for no-op).
// Latency: start@E0 -> write@E2, done E2..E3; start is ignored while busy (accepted again in the RELEASE cycle).
module gpr_move_sequencer #(
  parameter int NREGS  = 8,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              notReset,
  input  logic              start,
  input  logic [SEL_W-1:0]  src_sel,
  input  logic [SEL_W-1:0]  dst_sel,
  input  logic              imm_en,
  input  logic [DATA_W-1:0] imm_data,
  output logic [NREGS-1:0]  regNotOE,
  output logic [NREGS-1:0]  regNotLoad,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_oe,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_LOAD, S_RELEASE} state_t;

  localparam logic [NREGS-1:0] LSB = NREGS'(1);

  state_t             r_state;
  logic [NREGS-1:0]   r_not_oe;
  logic [NREGS-1:0]   r_not_ld;
  logic [DATA_W-1:0]  r_bus_data;
  logic               r_bus_oe;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [SEL_W-1:0]   r_dst;
  logic               r_noop;

  logic               w_dst_bad;
  logic               w_src_bad;
  logic               w_reject;
  logic [NREGS-1:0]   w_src_oe_n;
  logic [NREGS-1:0]   w_dst_ld_n;

  assign w_dst_bad  = int'(dst_sel) >= NREGS;
  assign w_src_bad  = !imm_en && (int'(src_sel) >= NREGS);
  assign w_reject   = w_dst_bad || w_src_bad;
  assign w_src_oe_n = ~(LSB << src_sel);
  assign w_dst_ld_n = ~(LSB << r_dst);

  // RELEASE behaves like IDLE for request sampling, giving 3-cycle throughput;
  // the old source drive drops on the same edge the new one starts, so strobes stay one-hot.
  always_ff @(posedge clock) begin
    if (!notReset) begin
      r_state    <= S_IDLE;
      r_not_oe   <= '1;
      r_not_ld   <= '1;
      r_bus_oe   <= 1'b0;
      r_bus_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_dst      <= '0;
      r_noop     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE, S_RELEASE: begin
          r_state    <= S_IDLE;
          r_not_oe   <= '1;
          r_not_ld   <= '1;
          r_bus_oe   <= 1'b0;
          r_bus_data <= '0;
          r_busy     <= 1'b0;
          if (start) begin
            if (w_reject) begin
              r_err <= 1'b1;
            end else begin
              r_state <= S_SETUP;
              r_busy  <= 1'b1;
              r_dst   <= dst_sel;
              r_noop  <= !imm_en && (src_sel == dst_sel);
              if (imm_en) begin
                r_bus_oe   <= 1'b1;
                r_bus_data <= imm_data;
              end else begin
                r_not_oe <= w_src_oe_n;
              end
            end
          end
        end
        S_SETUP: begin
          if (r_noop) begin
            r_state <= S_RELEASE;
            r_done  <= 1'b1;
          end else begin
            r_state  <= S_LOAD;
            r_not_ld <= w_dst_ld_n;
          end
        end
        S_LOAD: begin
          r_state  <= S_RELEASE;
          r_not_ld <= '1;
          r_done   <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign regNotOE   = r_not_oe;
  assign regNotLoad = r_not_ld;
  assign bus_data   = r_bus_data;
  assign bus_oe     = r_bus_oe;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_gpr_move_sequencer.sv
// Scoreboarded bench for gpr_move_sequencer (NREGS=6) with a behavioural GP register bank on the shared bus.
module tb_gpr_move_sequencer;
  localparam int NREGS  = 6;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              notReset;
  logic              start;
  logic [SEL_W-1:0]  src_sel;
  logic [SEL_W-1:0]  dst_sel;
  logic              imm_en;
  logic [DATA_W-1:0] imm_data;
  logic [NREGS-1:0]  regNotOE;
  logic [NREGS-1:0]  regNotLoad;
  logic [DATA_W-1:0] bus_data;
  logic              bus_oe;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clock = ~clock;

  gpr_move_sequencer #(.NREGS(NREGS), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .notReset(notReset), .start(start), .src_sel(src_sel),
    .dst_sel(dst_sel), .imm_en(imm_en), .imm_data(imm_data),
    .regNotOE(regNotOE), .regNotLoad(regNotLoad), .bus_data(bus_data),
    .bus_oe(bus_oe), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [NREGS-1:0]  noe;
    logic [NREGS-1:0]  nld;
    logic              boe;
    logic [DATA_W-1:0] bdat;
    logic              busy;
    logic              done;
    logic              err;
  } obs_t;

  obs_t cur;
  obs_t exp_v;
  obs_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;

  assign cur = {regNotOE, regNotLoad, bus_oe, bus_data, busy, done, err};

  // Behavioural register bank driven by the sequencer's strobes
  logic [DATA_W-1:0] gpr [NREGS] = '{default: '0};
  logic [DATA_W-1:0] data_bus;

  always_comb begin
    data_bus = '0;
    if (bus_oe) data_bus = bus_data;
    for (int i = 0; i < NREGS; i++)
      if (regNotOE[i] === 1'b0) data_bus = gpr[i];
  end

  always @(posedge clock)
    for (int i = 0; i < NREGS; i++)
      if (regNotLoad[i] === 1'b0) gpr[i] <= data_bus;

  function automatic obs_t mk(input int oe, input int ld, input logic boe,
                              input logic [DATA_W-1:0] d, input logic b,
                              input logic dn, input logic e);
    obs_t v;
    v.noe = '1;
    v.nld = '1;
    if (oe >= 0) v.noe[oe] = 1'b0;
    if (ld >= 0) v.nld[ld] = 1'b0;
    v.boe  = boe;
    v.bdat = d;
    v.busy = b;
    v.done = dn;
    v.err  = e;
    return v;
  endfunction

  function automatic obs_t idle_v();
    return mk(-1, -1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      vectors++;
      if ($countones(~regNotOE) > 1 || $countones(~regNotLoad) > 1 ||
          (bus_oe && (~regNotOE != '0)) || (regNotLoad != '1 && !(busy && !done))) begin
        miscompares++;
        $display("FAIL invariant @%0t: notOE=%b notLoad=%b bus_oe=%b busy=%b done=%b",
                 $time, regNotOE, regNotLoad, bus_oe, busy, done);
      end
      if (cur !== idle_v()) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output @%0t: got %h, nothing expected", $time, cur);
        end else begin
          exp_v = q.pop_front();
          if (cur !== exp_v) begin
            miscompares++;
            $display("FAIL output @%0t: got %h, expected %h", $time, cur, exp_v);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic req(input logic ie, input logic [SEL_W-1:0] s, input logic [SEL_W-1:0] d,
                     input logic [DATA_W-1:0] data);
    start    = 1'b1;
    imm_en   = ie;
    src_sel  = s;
    dst_sel  = d;
    imm_data = data;
    tick();
    start = 1'b0;
  endtask

  // Expected non-idle cycles of an accepted move, in order
  task automatic exp_move(input logic ie, input int s, input int d, input logic [DATA_W-1:0] data);
    int oe = ie ? -1 : s;
    logic [DATA_W-1:0] bd = ie ? data : '0;
    q.push_back(mk(oe, -1, ie, bd, 1'b1, 1'b0, 1'b0));
    if (!ie && s == d) begin
      q.push_back(mk(oe, -1, ie, bd, 1'b1, 1'b1, 1'b0));
    end else begin
      q.push_back(mk(oe, d, ie, bd, 1'b1, 1'b0, 1'b0));
      q.push_back(mk(oe, -1, ie, bd, 1'b1, 1'b1, 1'b0));
    end
  endtask

  task automatic exp_err();
    q.push_back(mk(-1, -1, 1'b0, '0, 1'b0, 1'b0, 1'b1));
  endtask

  initial begin
    notReset = 1'b0;
    start    = 1'b1;
    imm_en   = 1'b1;
    src_sel  = '0;
    dst_sel  = 3'd3;
    imm_data = 16'hBEEF;
    settle(2);
    check("reset_state", 32'(cur), 32'(idle_v()));
    start    = 1'b0;
    notReset = 1'b1;
    mon_en   = 1'b1;

    // Immediate load 0xBEEF -> r3
    exp_move(1'b1, 0, 3, 16'hBEEF);
    req(1'b1, 3'd0, 3'd3, 16'hBEEF);
    settle(4);
    check("imm_r3", 32'(gpr[3]), 32'hBEEF);
    check("drain_imm", q.size(), 0);

    // Register move r3 -> r5, start re-asserted in SETUP must be ignored
    exp_move(1'b0, 3, 5, '0);
    req(1'b0, 3'd3, 3'd5, '0);
    start   = 1'b1;
    src_sel = 3'd1;
    dst_sel = 3'd4;
    tick();
    start = 1'b0;
    settle(4);
    check("mov_r5", 32'(gpr[5]), 32'hBEEF);
    check("mov_r4_untouched", 32'(gpr[4]), 32'h0);
    check("drain_mov", q.size(), 0);

    // No-op move r2 -> r2
    exp_move(1'b0, 2, 2, '0);
    req(1'b0, 3'd2, 3'd2, '0);
    settle(4);
    check("noop_r2", 32'(gpr[2]), 32'h0);
    check("drain_noop", q.size(), 0);

    // Preload r1, then abort an imm move with reset sampled on the edge that would enter LOAD
    exp_move(1'b1, 0, 1, 16'hBEEF);
    req(1'b1, 3'd0, 3'd1, 16'hBEEF);
    settle(4);
    q.push_back(mk(-1, -1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0));
    req(1'b1, 3'd0, 3'd1, 16'h1234);
    notReset = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_strobes", 32'(cur), 32'(idle_v()));
    notReset = 1'b1;
    settle(3);
    check("abort_r1", 32'(gpr[1]), 32'hBEEF);
    check("drain_abort", q.size(), 0);

    // Range checks: dst=7, dst=NREGS, src=NREGS; src ignored for imm
    exp_err();
    req(1'b1, 3'd0, 3'd7, 16'h1111);
    settle(2);
    exp_err();
    req(1'b1, 3'd0, 3'd6, 16'h2222);
    settle(2);
    exp_err();
    req(1'b0, 3'd6, 3'd0, 16'h3333);
    settle(2);
    check("drain_err", q.size(), 0);
    check("err_r0", 32'(gpr[0]), 32'h0);
    exp_move(1'b1, 7, 5, 16'h0F0F);
    req(1'b1, 3'd7, 3'd5, 16'h0F0F);
    settle(4);
    check("imm_src_ignored_r5", 32'(gpr[5]), 32'h0F0F);

    // Back-to-back: second request accepted on the RELEASE cycle of the first
    exp_move(1'b1, 0, 0, 16'h00A5);
    exp_move(1'b1, 0, 4, 16'h5A00);
    req(1'b1, 3'd0, 3'd0, 16'h00A5);
    settle(2);
    req(1'b1, 3'd0, 3'd4, 16'h5A00);
    check("b2b_busy", 32'(busy), 32'h1);
    settle(4);
    check("b2b_r0", 32'(gpr[0]), 32'h00A5);
    check("b2b_r4", 32'(gpr[4]), 32'h5A00);
    check("drain_final", q.size(), 0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
